block_data_memory: RTL and testbench
====================================

Name: block_data_memory

Overview:
- Block-granular backing store that responds to the cache's miss/write-back requests; the responder end of the cache-to-memory interface.
- Accepts one read or write of a full line per request, waits a fixed latency, then completes.
- Instantiated beneath the cache; can also be driven standalone by a bench.

Parameters:
- BLOCK_SIZE, 16, line size in bytes; data width is BLOCK_SIZE*8 bits (128 by default).
- NUM_BLOCKS, 1024, number of lines stored; must be a power of two.
- DELAY, 50, access latency in clock edges; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- is_input_valid  input  1  request strobe; sampled only while mem_ready=1.
- addr  input  32  byte address; block index = addr[CLOG2(BLOCK_SIZE)+CLOG2(NUM_BLOCKS)-1 : CLOG2(BLOCK_SIZE)], upper bits ignored.
- mem_read  input  1  request is a line read.
- mem_write  input  1  request is a line write.
- din  input  BLOCK_SIZE*8  line write data.
- is_output_valid  output  1  one-cycle pulse marking valid read data on dout.
- dout  output  BLOCK_SIZE*8  line read data.
- mem_ready  output  1  1 = idle and able to accept a request.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high. Sampled high at an edge, it forces: state IDLE, counter 0, mem_ready=1, is_output_valid=0, dout=0, all NUM_BLOCKS lines cleared to 0.
  - reset asserted mid-request aborts that request. A pending write is not committed and no read pulse is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_ready=1.
  - A request is accepted at an edge with is_input_valid=1 and exactly one of mem_read or mem_write high.
  - On accept, latch the block index, op type and din. Load the counter with DELAY-1 and go to BUSY.
  - is_input_valid with both or neither of mem_read/mem_write is ignored: stay IDLE, no state change.
- BUSY:
  - mem_ready=0.
  - While counter != 0, decrement the counter at each edge.
  - At the edge where counter == 0 (edge T+DELAY, where T is the accept edge):
    - read: dout <= line[index] and is_output_valid <= 1.
    - write: line[index] <= latched din, dout unchanged.
    - In both cases go to DONE.
- DONE:
  - Lasts exactly one cycle. mem_ready=0.
  - is_output_valid=1 for a read, 0 for a write.
  - Next edge: go to IDLE, is_output_valid <= 0.
- Latency and timing:
  - mem_ready is low for exactly DELAY+1 cycles per accepted request.
  - Read data is visible in the cycle after edge T+DELAY.
  - The earliest next accept is edge T+DELAY+2.
- Inputs ignored while not IDLE: is_input_valid and all request fields are ignored in BUSY and DONE. No queuing, no error flag.
- Data hold and commit:
  - dout holds the last read line until the next read completes or reset.
  - din, addr and op are captured at accept; changes afterwards have no effect.
- Memory semantics:
  - Read-after-write to the same block returns the new data, since the write commits before DONE.
  - Index wrap-around: address bits above the index field alias; addr and addr + NUM_BLOCKS*BLOCK_SIZE map to the same line.
- Implementation constraints:
  - Behavioural model; no byte enables (full-line writes only).
  - Counter width is CLOG2(DELAY)+1.

Test Plan:
- Reset then idle (DELAY=4): assert reset 2 cycles -> mem_ready=1, is_output_valid=0, dout=0; read of addr 0x40 completes with dout=0.
- Write then read (DELAY=4): write addr 0x100, din=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D at edge T.
  - mem_ready=0 for 5 cycles and no is_output_valid.
  - Read 0x100 accepted at T+6 -> is_output_valid=1 for exactly one cycle after edge T+10, with dout equal to that value.
- Busy rejection: while BUSY with a read of 0x100, drive a write of 0x100 with din=0 -> write ignored; a later read of 0x100 still returns the original data.
- Illegal request: is_input_valid=1 with mem_read=mem_write=1 -> mem_ready stays 1, no pulse, memory unchanged.
- Aliasing (NUM_BLOCKS=1024, BLOCK_SIZE=16): write 0x00000010 with din=1, then read 0x00004010 -> dout=1.
- Reset mid-write: accept a write of 0x200 with din=5, assert reset 2 cycles later -> mem_ready=1 next cycle; a read of 0x200 returns 0.

Source files
------------

// File: rtl/block_data_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : block_data_memory_if
// Purpose  : Cache-to-memory line request bus. The cache (or a bench) is the
//            master; block_data_memory is the slave/responder.
// Signals  : is_input_valid - request strobe (master -> slave)
//            addr           - 32-bit byte address (master -> slave)
//            mem_read       - line read request (master -> slave)
//            mem_write      - line write request (master -> slave)
//            din            - line write data (master -> slave)
//            is_output_valid- one-cycle read-data-valid pulse (slave -> master)
//            dout           - line read data (slave -> master)
//            mem_ready      - responder idle, request may be issued
// Revision : 1.0 - initial release
// ============================================================================
interface block_data_memory_if #(
    parameter int BLOCK_SIZE = 16
) ();

    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_SIZE*8-1:0] din;
    logic                    is_output_valid;
    logic [BLOCK_SIZE*8-1:0] dout;
    logic                    mem_ready;

    modport master (
        output is_input_valid,
        output addr,
        output mem_read,
        output mem_write,
        output din,
        input  is_output_valid,
        input  dout,
        input  mem_ready
    );

    modport slave (
        input  is_input_valid,
        input  addr,
        input  mem_read,
        input  mem_write,
        input  din,
        output is_output_valid,
        output dout,
        output mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/block_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : block_data_memory
// Purpose  : Block-granular backing store answering cache line fills and
//            write-backs. One full-line read or write per request, completed
//            a fixed DELAY clock edges after the request is accepted.
// Ports    : clk    - system clock, rising edge
//            reset  - synchronous active-high reset; clears every line
//            bus    - block_data_memory_if.slave request/response bus
// Params   : BLOCK_SIZE - line size in bytes (data width BLOCK_SIZE*8)
//            NUM_BLOCKS - number of lines, power of two, at least 2
//            DELAY      - access latency in clock edges, at least 1
// Timing   : accept at edge T, complete at edge T+DELAY, one DONE cycle,
//            back in IDLE after edge T+DELAY+1; mem_ready low DELAY+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module block_data_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 1024,
    parameter int DELAY      = 50
) (
    input  wire logic          clk,
    input  wire logic          reset,
    block_data_memory_if.slave bus
);

    localparam int c_DATA_W = BLOCK_SIZE * 8;
    localparam int c_OFF_W  = $clog2(BLOCK_SIZE);
    localparam int c_IDX_W  = $clog2(NUM_BLOCKS);
    localparam int c_CNT_W  = $clog2(DELAY) + 1;

    // Counter is preloaded so that the zero count is seen exactly at edge
    // T+DELAY, where T is the accept edge.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_fire;
    logic                  w_mem_ready;
    logic [c_IDX_W-1:0]    w_index;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_index;
    logic                  r_is_write;
    logic [c_DATA_W-1:0]   r_din;
    logic [c_DATA_W-1:0]   r_dout;
    logic                  r_out_valid;
    logic [c_DATA_W-1:0]   r_mem [NUM_BLOCKS];

    // Dropping the byte-offset bits and truncating to the index width makes
    // every address above the index field alias onto the same line.
    assign w_index = c_IDX_W'(bus.addr >> c_OFF_W);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        w_mem_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_ready = 1'b1;
                // Only a request with exactly one op bit set is legal; any
                // other combination is silently dropped.
                if (bus.is_input_valid && (bus.mem_read ^ bus.mem_write)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_fire       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture, latency counter, line storage and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_index     <= '0;
            r_is_write  <= 1'b0;
            r_din       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            // Clearing the array here also discards any write still in
            // flight, so an aborted request never commits.
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // High only for the DONE cycle that follows a completed read.
            r_out_valid <= w_fire & ~r_is_write;

            if (w_accept) begin
                r_index    <= w_index;
                r_is_write <= bus.mem_write;
                r_din      <= bus.din;
                r_cnt      <= c_CNT_LOAD;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end

            if (w_fire) begin
                if (r_is_write) begin
                    r_mem[r_index] <= r_din;
                end else begin
                    r_dout <= r_mem[r_index];
                end
            end
        end
    end

    assign bus.mem_ready       = w_mem_ready;
    assign bus.is_output_valid = r_out_valid;
    assign bus.dout            = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_block_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_data_memory
// Purpose  : Self-checking bench for block_data_memory (DELAY=4, 1024 x 16B).
//            A table of line requests is applied back to back; read results
//            are predicted into a scoreboard queue and popped by a monitor
//            when the read-valid pulse appears. Hand-written sequences cover
//            reset, illegal requests and reset during a write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_data_memory;

    localparam int BS  = 16;
    localparam int NB  = 1024;
    localparam int DLY = 4;
    localparam int DW  = BS * 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    block_data_memory_if #(.BLOCK_SIZE(BS)) bus ();

    block_data_memory #(
        .BLOCK_SIZE (BS),
        .NUM_BLOCKS (NB),
        .DELAY      (DLY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_dout;

    typedef struct {
        bit            is_wr;
        logic [31:0]   addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
        bit            noise;
        string         name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read-valid pulse must match a queued prediction.
    always @(negedge clk) begin
        if (bus.is_output_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: is_output_valid=1 with nothing expected");
            end else begin
                check("read_data", bus.dout, exp_q.pop_front());
            end
        end
    end

    // Issue one request at a negedge while idle, then follow it to completion.
    // With noise set, a write of zero to the same address is driven during
    // BUSY/DONE; it must be ignored. Otherwise the request fields are
    // scrambled after accept to show they were captured.
    task automatic do_req(input bit is_wr, input logic [31:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp, input bit noise, input string name);
        int low;
        int pulses;
        int pos;
        check({name, "_ready_before"}, bus.mem_ready, 1);
        bus.addr           = a;
        bus.din            = d;
        bus.mem_read       = !is_wr;
        bus.mem_write      = is_wr;
        bus.is_input_valid = 1'b1;
        if (!is_wr) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus.is_input_valid = noise;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b1;
        bus.din            = noise ? '0 : ~d;
        bus.addr           = noise ? a : (a ^ 32'h0000_0030);
        low    = 0;
        pulses = 0;
        pos    = 0;
        while (bus.mem_ready === 1'b0 && low < 4 * DLY + 10) begin
            low++;
            if (bus.is_output_valid === 1'b1) begin
                pulses++;
                pos = low;
            end
            @(negedge clk);
        end
        bus.is_input_valid = 1'b0;
        check({name, "_busy_cycles"}, low, DLY + 1);
        check({name, "_pulse_count"}, pulses, is_wr ? 0 : 1);
        if (!is_wr) check({name, "_pulse_pos"}, pos, DLY + 1);
        check({name, "_valid_after"}, bus.is_output_valid, 0);
        if (!is_wr) last_dout = exp;
        else        check({name, "_dout_hold"}, bus.dout, last_dout);
        check({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat_a;
        logic [DW-1:0] pat_b;
        logic [DW-1:0] pat_d;
        pat_d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        pat_a = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        pat_b = 128'h11112222_33334444_55556666_77778888;

        //          wr    addr           din     exp     noise  name
        vecs[0]  = '{1'b0, 32'h0000_0040, '0,    '0,     1'b0, "rd_40_empty"};
        vecs[1]  = '{1'b1, 32'h0000_0100, pat_d, '0,     1'b0, "wr_100"};
        vecs[2]  = '{1'b0, 32'h0000_0100, '0,    pat_d,  1'b1, "rd_100_busy_wr"};
        vecs[3]  = '{1'b0, 32'h0000_0100, '0,    pat_d,  1'b0, "rd_100_kept"};
        vecs[4]  = '{1'b1, 32'h0000_0010, 128'd1, '0,    1'b0, "wr_10"};
        vecs[5]  = '{1'b0, 32'h0000_4010, '0,    128'd1, 1'b0, "rd_4010_alias"};
        vecs[6]  = '{1'b1, 32'h0000_3FF0, pat_a, '0,     1'b0, "wr_last_blk"};
        vecs[7]  = '{1'b0, 32'hFFFF_FFF0, '0,    pat_a,  1'b0, "rd_top_alias"};
        vecs[8]  = '{1'b1, 32'h0000_010C, pat_b, '0,     1'b1, "wr_10c_offset"};
        vecs[9]  = '{1'b0, 32'h0000_0100, '0,    pat_b,  1'b0, "rd_100_new"};
        vecs[10] = '{1'b0, 32'h0000_0000, '0,    '0,     1'b0, "rd_0_untouched"};

        bus.is_input_valid = 1'b0;
        bus.addr           = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.din            = '0;
        reset              = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_ready", bus.mem_ready, 1);
        check("rst_out_valid", bus.is_output_valid, 0);
        check("rst_dout", bus.dout, '0);
        reset     = 1'b0;
        last_dout = '0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].is_wr, vecs[i].addr, vecs[i].din, vecs[i].exp,
                   vecs[i].noise, vecs[i].name);
        end

        // Illegal requests: both op bits, then neither; must never be accepted.
        bus.addr           = 32'h0000_0100;
        bus.din            = '0;
        bus.is_input_valid = 1'b1;
        bus.mem_read       = 1'b1;
        bus.mem_write      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_both_ready", bus.mem_ready, 1);
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("illegal_none_ready", bus.mem_ready, 1);
        end
        bus.is_input_valid = 1'b0;
        do_req(1'b0, 32'h0000_0100, '0, pat_b, 1'b0, "rd_100_after_illegal");

        // Reset two cycles after accepting a write: write must be lost.
        bus.addr           = 32'h0000_0200;
        bus.din            = 128'd5;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b1;
        bus.is_input_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.is_input_valid = 1'b0;
        check("midwr_busy", bus.mem_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midwr_ready", bus.mem_ready, 1);
        check("midwr_valid", bus.is_output_valid, 0);
        check("midwr_dout", bus.dout, '0);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        last_dout = '0;
        @(negedge clk);
        do_req(1'b0, 32'h0000_0200, '0, '0, 1'b0, "rd_200_aborted");
        do_req(1'b0, 32'h0000_0100, '0, '0, 1'b0, "rd_100_cleared");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
